image_scan_arbiter: RTL and testbench

Shares one 16x16 image-tile read port between two requesters and sequences a full raster scan for the winner. Generates row/column pixel addresses, absorbs the memory's 1-cycle read latency through a 2-entry output FIFO, and delivers pixels downstream on a valid/ready stream. Sits between the tile pixel memory and the consumers: display refresh (requester 0) and overlay/compare engine (requester 1).

---
 rtl/image_scan_arbiter.sv | 126 ++++++++++++
 tb/tb_image_scan_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_scan_arbiter.sv
// Two-requester arbiter that raster-scans a 16x16 pixel tile for the winner,
// hiding the memory's 1-cycle read latency behind a 2-entry output FIFO.
module image_scan_arbiter #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req,
  input  logic              abort,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              mem_rd,
  output logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  output logic              pix_owner,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [3:0]        row, col;
  logic              owner, last_owner, sel_owner;
  logic              pending, pending_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_nxt;
  logic [2:0]        outstanding;
  logic              pop, issue, last_addr, done, frame_done_q;

  always_comb begin
    pop         = (count != 2'd0) & pix_ready;
    // Credit: entries held plus the read in flight, after this cycle's pop.
    outstanding = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    issue       = (state == SCAN) && (outstanding < 3'd2);
    last_addr   = (row == 4'(ROWS - 1)) && (col == 4'(COLS - 1));
    count_nxt   = count + {1'b0, pending} - {1'b0, pop};
    sel_owner   = (req == 2'b11) ? ~last_owner : req[1];
    state_nxt   = state;
    done        = 1'b0;
    case (state)
      IDLE:  if (req != 2'b00) state_nxt = SCAN;
      SCAN: begin
        if (abort) state_nxt = IDLE;
        else if (issue && last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort) state_nxt = IDLE;
        else if (!pending && count_nxt == 2'd0) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= done;
      if (state == IDLE && req != 2'b00) owner <= sel_owner;
      pending      <= issue;
      pending_last <= last_addr;
      if (issue) begin
        if (col == 4'(COLS - 1)) begin
          col <= '0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
      if (pending) begin
        fifo_data[wr_ptr] <= mem_data;
        fifo_last[wr_ptr] <= pending_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      if (done) last_owner <= owner;
      // Abort discards the in-flight read and all buffered pixels.
      if (abort && state != IDLE) begin
        pending    <= 1'b0;
        count      <= '0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
        row        <= '0;
        col        <= '0;
        last_owner <= owner;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign grant      = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign mem_rd     = issue;
  assign mem_addr   = {row, col};
  assign pix_valid  = (count != 2'd0);
  assign pix_data   = fifo_data[rd_ptr];
  assign pix_last   = pix_valid & fifo_last[rd_ptr];
  assign pix_owner  = owner;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_scan_arbiter.sv
// Directed bench for image_scan_arbiter: a transaction-level model of scan
// progress checks every output each cycle, plus literal timing/count checks.
module tb_image_scan_arbiter;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic [1:0]        req = 2'b00;
  logic              abort = 1'b0;
  logic [1:0]        grant;
  logic              busy, mem_rd, pix_valid, pix_last, pix_owner, frame_done;
  logic              pix_ready = 1'b1;
  logic [7:0]        mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] pix_data;

  int errors = 0;
  int checks = 0;

  image_scan_arbiter #(.COLS(16), .ROWS(16), .DATA_W(DATA_W)) dut (
    .clk(clk), .nrst(nrst), .req(req), .abort(abort), .grant(grant),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .pix_owner(pix_owner), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pattern(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Pixel memory with one cycle of read latency.
  always @(posedge clk) if (mem_rd) mem_data <= pattern(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan progress as counts of reads issued and pixels accepted.
  bit mon_en = 1'b0;
  int cyc = 0;
  int issue_q[$];
  int m_reads = 0, m_acc = 0, m_landed = 0;
  bit m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_fd = 1'b0;
  int pops = 0, lasts = 0;

  always @(negedge clk) if (mon_en) begin
    bit ev, pop, er;
    logic [1:0] eg;
    cyc++;
    while (issue_q.size() > 0 && issue_q[0] <= cyc - 2) begin
      void'(issue_q.pop_front());
      m_landed++;
    end
    ev  = m_busy && (m_landed > m_acc);
    pop = ev && pix_ready;
    er  = m_busy && (m_reads < 256) && ((m_reads - m_acc - (pop ? 1 : 0)) < 2);
    eg  = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("mem_rd", 32'(mem_rd), 32'(er));
    chk("pix_valid", 32'(pix_valid), 32'(ev));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (er) chk("mem_addr", 32'(mem_addr), 32'(m_reads));
    if (ev) begin
      chk("pix_data", 32'(pix_data), 32'(pattern(8'(m_acc))));
      chk("pix_last", 32'(pix_last), 32'(m_acc == 255));
      chk("pix_owner", 32'(pix_owner), 32'(m_owner));
    end
    if (pix_valid && pix_ready) begin
      pops++;
      if (pix_last) lasts++;
    end
    m_fd = 1'b0;
    if (nrst) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      issue_q.delete();
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        m_busy   = 1'b1;
        m_owner  = (req == 2'b11) ? ~m_last : req[1];
        m_reads  = 0; m_acc = 0; m_landed = 0;
        issue_q.delete();
      end
    end else if (abort) begin
      m_busy = 1'b0;
      m_last = m_owner;
      issue_q.delete();
    end else begin
      if (er) begin
        issue_q.push_back(cyc);
        m_reads++;
      end
      if (pop) m_acc++;
      if (m_acc == 256) begin
        m_busy = 1'b0;
        m_fd   = 1'b1;
        m_last = m_owner;
      end
    end
  end

  // Back-pressure pattern generator.
  bit         bp_en = 1'b0;
  logic [9:0] bp_pat = 10'b1011011001;
  int         bp_i = 0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) begin
      pix_ready = bp_pat[bp_i];
      bp_i = (bp_i + 1) % 10;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      n++;
      if (frame_done) return;
    end
    errors++;
    $display("FAIL frame_done_timeout: got none expected pulse within 3000 cycles");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_pix_last"}, 32'(pix_last), 0);
    chk({tag, "_pix_owner"}, 32'(pix_owner), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  initial begin
    int n, p0, l0;
    bit found;
    step; step;
    chk_all_zero("reset");
    mon_en = 1'b1;
    nrst = 1'b0;
    step;

    // Single scan, full throughput: frame_done 259 cycles after the request cycle.
    p0 = pops; l0 = lasts;
    req = 2'b01;
    step;
    chk("single_grant", 32'(grant), 32'h1);
    req = 2'b00;
    wait_fd(n);
    chk("single_latency", n, 259 - 1);
    chk("single_pixels", pops - p0, 256);
    chk("single_lasts", lasts - l0, 1);
    step;

    // Reset, then tie with round robin; middle scan under back-pressure.
    nrst = 1'b1; step; nrst = 1'b0;
    req = 2'b11;
    step;
    chk("tie_first", 32'(grant), 32'h1);
    wait_fd(n);
    bp_en = 1'b1;
    step;
    chk("tie_second", 32'(grant), 32'h2);
    p0 = pops;
    wait_fd(n);
    chk("bp_pixels", pops - p0, 256);
    bp_en = 1'b0; pix_ready = 1'b1;
    step;
    chk("tie_third", 32'(grant), 32'h1);
    req = 2'b00;
    wait_fd(n);
    step;

    // Abort while pixel 0x37 is at the head.
    bp_en = 1'b1;
    req = 2'b01;
    step;
    req = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (pix_valid && pix_data[7:0] == 8'h37) found = 1'b1;
      else step;
    end
    chk("abort_reach_37", 32'(found), 1);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(pix_valid), 0);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_no_fd", 32'(frame_done), 0);
    req = 2'b11;
    step;
    chk("abort_regrant", 32'(grant), 32'h2);
    req = 2'b00;
    wait_fd(n);
    bp_en = 1'b0;
    step;

    // Reset mid-scan with the FIFO full, then a one-cycle request from requester 1.
    pix_ready = 1'b0;
    req = 2'b01;
    step;
    req = 2'b00;
    repeat (8) step;
    chk("stall_valid", 32'(pix_valid), 1);
    chk("stall_no_rd", 32'(mem_rd), 0);
    nrst = 1'b1;
    step;
    chk_all_zero("midreset");
    nrst = 1'b0;
    pix_ready = 1'b1;
    req = 2'b10;
    step;
    req = 2'b00;
    chk("drop_grant", 32'(grant), 32'h2);
    chk("drop_first_addr", 32'(mem_addr), 0);
    p0 = pops;
    wait_fd(n);
    chk("drop_pixels", pops - p0, 256);
    step; step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
